// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that shares one FIFO write port between REQUESTERS producers.
// Defining FIFO_WRITE_ARBITER_BURST_LOCK_EN keeps the grant on one requester until its last beat.
module fifo_write_arbiter #(
    parameter int WIDTH       = 8,
    parameter int REQUESTERS  = 4,
    parameter int INDEX_WIDTH = $clog2(REQUESTERS)
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [REQUESTERS-1:0]         request_enable,
    input  logic [REQUESTERS*WIDTH-1:0]   request_data,
    input  logic [REQUESTERS-1:0]         request_last,
    output logic [REQUESTERS-1:0]         request_grant,
    output logic                          write_enable,
    output logic [WIDTH-1:0]              write_data,
    input  logic                          write_full,
    output logic [INDEX_WIDTH-1:0]        grant_index
);

    localparam int SUM_W = INDEX_WIDTH + 1;
    localparam logic [SUM_W-1:0] REQ_COUNT = SUM_W'(REQUESTERS);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(REQUESTERS - 1);

    logic [INDEX_WIDTH-1:0]    pointer_q, pointer_d;
    logic [INDEX_WIDTH-1:0]    grant_index_q, grant_index_d;

    logic [REQUESTERS-1:0]     eligible;
    logic [2*REQUESTERS-1:0]   eligible_double;
    logic [REQUESTERS-1:0]     eligible_rot;
    logic                      found;
    logic [INDEX_WIDTH-1:0]    offset;
    logic [SUM_W-1:0]          sum;
    logic [INDEX_WIDTH-1:0]    sel;
    logic [INDEX_WIDTH-1:0]    sel_plus_one;
    logic                      grant_valid;
    logic [WIDTH-1:0]          data_arr [REQUESTERS];

    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_data_split
            assign data_arr[gi] = request_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef FIFO_WRITE_ARBITER_BURST_LOCK_EN
    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] owner_q, owner_d;

    // While locked only the burst owner may win; everyone else is masked out.
    assign eligible = (state_q == ST_LOCKED)
                    ? (request_enable & (REQUESTERS'(1) << owner_q))
                    : request_enable;
`else
    logic unused_last;

    assign unused_last = ^request_last;
    assign eligible    = request_enable;
`endif

    // Rotate so bit 0 is the requester at the priority pointer; explicit wrap for any REQUESTERS.
    assign eligible_double = {eligible, eligible};
    assign eligible_rot    = eligible_double[pointer_q +: REQUESTERS];

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            if (eligible_rot[k]) begin
                found  = 1'b1;
                offset = INDEX_WIDTH'(k);
            end
        end
    end

    always_comb begin
        sum = {1'b0, pointer_q} + {1'b0, offset};
        if (sum >= REQ_COUNT) begin
            sum = sum - REQ_COUNT;
        end
        sel          = sum[INDEX_WIDTH-1:0];
        sel_plus_one = (sel == LAST_INDEX) ? '0 : sel + 1'b1;
    end

    assign grant_valid   = found & ~write_full & resetn;
    assign request_grant = grant_valid ? (REQUESTERS'(1) << sel) : '0;
    assign write_enable  = grant_valid;
    assign write_data    = grant_valid ? data_arr[sel] : '0;
    assign grant_index   = grant_index_q;

    always_comb begin
        pointer_d     = pointer_q;
        grant_index_d = grant_index_q;
`ifdef FIFO_WRITE_ARBITER_BURST_LOCK_EN
        state_d       = state_q;
        owner_d       = owner_q;
        if (grant_valid) begin
            grant_index_d = sel;
            if (request_last[sel]) begin
                pointer_d = sel_plus_one;
                state_d   = ST_IDLE;
            end else begin
                state_d   = ST_LOCKED;
                owner_d   = sel;
            end
        end
`else
        if (grant_valid) begin
            grant_index_d = sel;
            pointer_d     = sel_plus_one;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pointer_q     <= '0;
            grant_index_q <= '0;
`ifdef FIFO_WRITE_ARBITER_BURST_LOCK_EN
            state_q       <= ST_IDLE;
            owner_q       <= '0;
`endif
        end else begin
            pointer_q     <= pointer_d;
            grant_index_q <= grant_index_d;
`ifdef FIFO_WRITE_ARBITER_BURST_LOCK_EN
            state_q       <= state_d;
            owner_q       <= owner_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a behavioural round-robin model (honours FIFO_WRITE_ARBITER_BURST_LOCK_EN).
module tb_fifo_write_arbiter;

    localparam int W = 8;
    localparam int R = 4;
    localparam int IW = $clog2(R);
`ifdef FIFO_WRITE_ARBITER_BURST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
    int          exp_who [5] = '{0, 0, 0, 1, 1};
    logic [7:0]  exp_dat [5] = '{8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hC1};
`else
    localparam bit LOCK_EN = 1'b0;
    int          exp_who [5] = '{0, 1, 0, 1, 0};
    logic [7:0]  exp_dat [5] = '{8'hB0, 8'hC0, 8'hB1, 8'hC1, 8'hB2};
`endif

    logic            clock = 1'b0;
    logic            resetn;
    logic [R-1:0]    request_enable;
    logic [R*W-1:0]  request_data;
    logic [R-1:0]    request_last;
    logic [R-1:0]    request_grant;
    logic            write_enable;
    logic [W-1:0]    write_data;
    logic            write_full;
    logic [IW-1:0]   grant_index;

    int checks = 0;
    int errors = 0;

    fifo_write_arbiter #(.WIDTH(W), .REQUESTERS(R)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .request_enable (request_enable),
        .request_data   (request_data),
        .request_last   (request_last),
        .request_grant  (request_grant),
        .write_enable   (write_enable),
        .write_data     (write_data),
        .write_full     (write_full),
        .grant_index    (grant_index)
    );

    always #5 clock = ~clock;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: priority pointer, last grant, optional burst owner.
    int  m_ptr = 0;
    int  m_gidx = 0;
    bit  m_locked = 1'b0;
    int  m_owner = 0;
    bit  started = 1'b0;

    function automatic int model_pick();
        if (!resetn || write_full) return -1;
        for (int k = 0; k < R; k++) begin
            int i;
            i = (m_ptr + k) % R;
            if (request_enable[i] && (!LOCK_EN || !m_locked || i == m_owner)) return i;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        int g;
        started <= 1'b1;
        if (!resetn) begin
            m_ptr    <= 0;
            m_gidx   <= 0;
            m_locked <= 1'b0;
        end else begin
            g = model_pick();
            if (g >= 0) begin
                m_gidx <= g;
                if (LOCK_EN && !request_last[g]) begin
                    m_locked <= 1'b1;
                    m_owner  <= g;
                end else begin
                    m_locked <= 1'b0;
                    m_ptr    <= (g + 1) % R;
                end
            end
        end
    end

    always @(negedge clock) begin
        int g;
        logic [R-1:0] ev;
        logic [W-1:0] ed;
        if (started) begin
            g  = model_pick();
            ev = (g < 0) ? '0 : (R'(1) << g);
            ed = (g < 0) ? '0 : request_data[g*W +: W];
            check("cmp_grant", 32'(request_grant), 32'(ev));
            check("cmp_wen", 32'(write_enable), 32'(g >= 0));
            check("cmp_wdata", 32'(write_data), 32'(ed));
            check("cmp_gidx", 32'(grant_index), 32'(m_gidx));
        end
    end

    logic [R-1:0] g_seen;

    task automatic expect_cycle(input string name, input int who, input logic [7:0] data, input int gidx);
        @(negedge clock);
        g_seen = request_grant;
        check({name, "_grant"}, 32'(request_grant), (who < 0) ? 32'd0 : (32'd1 << who));
        check({name, "_data"}, 32'(write_data), (who < 0) ? 32'd0 : 32'(data));
        if (gidx >= 0) check({name, "_gidx"}, 32'(grant_index), 32'(gidx));
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic en, input logic [7:0] d, input logic last);
        request_enable[i]       = en;
        request_data[i*W +: W]  = d;
        request_last[i]         = last;
    endtask

    initial begin
        int b0;
        int c1;
        resetn       = 1'b0;
        write_full   = 1'b0;
        request_enable = '0;
        request_data   = '0;
        request_last   = '0;
        for (int i = 0; i < R; i++) set_req(i, 1'b1, 8'(8'hA0 + i), 1'b1);

        // Reset gating and first grant
        expect_cycle("reset", -1, 8'h00, -1);
        expect_cycle("reset", -1, 8'h00, 0);
        resetn = 1'b1;
        expect_cycle("first", 0, 8'hA0, 0);

        // Round robin over all requesters
        for (int c = 1; c < 8; c++) expect_cycle("rr", c % 4, 8'(8'hA0 + c % 4), -1);

        // Sparse with wrap
        request_enable = 4'b0010;
        expect_cycle("sparse1", 1, 8'hA1, 3);
        request_enable = 4'b1010;
        expect_cycle("sparse3", 3, 8'hA3, 1);
        expect_cycle("sparse1b", 1, 8'hA1, 3);
        expect_cycle("sparse3b", 3, 8'hA3, 1);

        // Back-pressure with requester 2 next
        request_enable = 4'b0010;
        expect_cycle("bp_setup", 1, 8'hA1, 3);
        request_enable = 4'b1111;
        write_full = 1'b1;
        for (int c = 0; c < 5; c++) expect_cycle("bp_full", -1, 8'h00, 1);
        write_full = 1'b0;
        expect_cycle("bp_r2", 2, 8'hA2, 1);
        expect_cycle("bp_r3", 3, 8'hA3, 2);
        expect_cycle("bp_r0", 0, 8'hA0, 3);
        expect_cycle("bp_r1", 1, 8'hA1, 0);

        // Burst: requester 0 sends three beats while requester 1 keeps requesting
        resetn = 1'b0;
        request_enable = '0;
        expect_cycle("burst_rst", -1, 8'h00, -1);
        resetn = 1'b1;
        b0 = 0;
        c1 = 0;
        set_req(0, 1'b1, 8'hB0, 1'b0);
        set_req(1, 1'b1, 8'hC0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            expect_cycle("burst", exp_who[c], exp_dat[c], -1);
            if (g_seen[0]) begin
                b0++;
                if (b0 == 3) set_req(0, 1'b0, 8'h00, 1'b1);
                else         set_req(0, 1'b1, 8'(8'hB0 + b0), b0 == 2);
            end
            if (g_seen[1]) begin
                c1++;
                set_req(1, 1'b1, 8'(8'hC0 + c1), 1'b1);
            end
        end

        // Reset while locked on requester 2
        request_enable = '0;
        set_req(2, 1'b1, 8'hD2, 1'b0);
        expect_cycle("lock2", 2, 8'hD2, -1);
        set_req(0, 1'b1, 8'hD0, 1'b1);
        set_req(1, 1'b1, 8'hD1, 1'b1);
        resetn = 1'b0;
        expect_cycle("midrst", -1, 8'h00, -1);
        expect_cycle("midrst", -1, 8'h00, 0);
        resetn = 1'b1;
        expect_cycle("after_rst", 0, 8'hD0, 0);

        // Randomized traffic; requests are held until granted, occasionally dropped
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            g_seen = request_grant;
            @(posedge clock);
            #1;
            for (int i = 0; i < R; i++) begin
                if (g_seen[i] || !request_enable[i]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(i, 1'b1, 8'($urandom), $urandom_range(0, 2) != 0);
                    else
                        request_enable[i] = 1'b0;
                end else if ($urandom_range(0, 31) == 0) begin
                    request_enable[i] = 1'b0;
                end
            end
            write_full = ($urandom_range(0, 3) == 0);
            resetn     = ($urandom_range(0, 99) != 0);
        end

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
